ribm_kes_scheduler: RTL and testbench

Sequencing controller between the syndrome stage and one ribm_solver_3t instance.
- Buffers up to 2 syndrome vectors with their codeword tags.
- Bypasses all-zero syndromes without launching the solver.
- Launches the solver one codeword at a time and captures its sigma/v result.
- Delivers results in order to the Chien/Forney stage over a valid/ready handshake.

---
 rtl/ribm_pkg.sv | 38 +++
 rtl/ribm_syn_fifo.sv | 50 +++++
 rtl/ribm_kes_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ribm_kes_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ribm_pkg.sv
// Shared types and constants for the RiBM key-equation-solver front end.
package ribm_pkg;

   localparam int unsigned T    = 11;
   localparam int unsigned W    = 10;
   localparam int unsigned TAGW = 8;
   localparam int unsigned CNTW = 16;
   localparam int unsigned NSYN = 2 * T + 1;
   localparam int unsigned DEGW = $clog2(T + 1);

   localparam logic [W-1:0] GF_ZERO = '0;
   localparam logic [W-1:0] GF_ONE  = W'(1);

   typedef logic [NSYN-1:0][W-1:0] syn_vec_t;
   typedef logic [T:0][W-1:0]      sigma_vec_t;
   typedef logic [T-1:0][W-1:0]    v_vec_t;

   typedef struct packed {
      syn_vec_t        syn;
      logic [TAGW-1:0] tag;
      logic            zero;
   } syn_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HOLD
   } kes_state_e;

   // Index of the highest nonzero coefficient; 0 when sigma is all zero.
   function automatic logic [DEGW-1:0] sigma_deg(input sigma_vec_t s);
      sigma_deg = '0;
      for (int unsigned i = 0; i <= T; i++) begin
         if (s[i] != GF_ZERO) sigma_deg = DEGW'(i);
      end
   endfunction

endpackage

// File: rtl/ribm_syn_fifo.sv
// Two-entry syndrome/tag buffer; the zero flag is computed once on push.
module ribm_syn_fifo
   import ribm_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_push,
   input  syn_vec_t        i_syn,
   input  logic [TAGW-1:0] i_tag,
   input  logic            i_pop,
   output syn_entry_t      o_head,
   output logic            o_full,
   output logic            o_empty
);

   syn_entry_t r_mem [2];
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_cnt;
   logic       w_push;
   logic       w_pop;
   logic       w_zero;

   // s[0] does not take part in the zero test.
   assign w_zero = ~|i_syn[NSYN-1:1];
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= '{syn: i_syn, tag: i_tag, zero: w_zero};
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_full  = (r_cnt == 2'd2);
   assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/ribm_kes_scheduler.sv
// Sequences buffered syndromes through one RiBM solver, bypassing zero syndromes,
// and returns results in order through a single registered output slot.
module ribm_kes_scheduler
   import ribm_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            s_valid_i,
   output logic            s_ready_o,
   input  syn_vec_t        s_syn_i,
   input  logic [TAGW-1:0] s_tag_i,
   output logic            kes_start_o,
   output logic            kes_syn_valid_o,
   output syn_vec_t        kes_syn_o,
   input  logic            kes_busy_i,
   input  logic            kes_done_i,
   input  sigma_vec_t      kes_sigma_i,
   input  v_vec_t          kes_v_i,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output sigma_vec_t      m_sigma_o,
   output v_vec_t          m_v_o,
   output logic [DEGW-1:0] m_deg_o,
   output logic [TAGW-1:0] m_tag_o,
   output logic            m_bypass_o,
   output logic [CNTW-1:0] cnt_solved_o,
   output logic [CNTW-1:0] cnt_bypass_o
);

   kes_state_e      r_state, w_state_nxt;
   syn_entry_t      w_head;
   logic            w_full, w_empty, w_push, w_pop;
   logic            w_out_free, w_load, w_load_byp, w_launch;
   sigma_vec_t      w_ld_sigma;
   v_vec_t          w_ld_v;
   logic [TAGW-1:0] w_ld_tag;
   logic [TAGW-1:0] r_tag_fly;

   logic            r_valid, r_bypass;
   sigma_vec_t      r_sigma;
   v_vec_t          r_v;
   logic [DEGW-1:0] r_deg;
   logic [TAGW-1:0] r_tag;
   logic [CNTW-1:0] r_cnt_solved, r_cnt_bypass;

   assign w_push = s_valid_i && !w_full;

   ribm_syn_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_syn   (s_syn_i),
      .i_tag   (s_tag_i),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_out_free = !r_valid || m_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Launch/bypass/capture decisions; the solver holds its outputs while in HOLD.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_load_byp  = 1'b0;
      w_launch    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               if (w_head.zero) begin
                  if (w_out_free) begin
                     w_load     = 1'b1;
                     w_load_byp = 1'b1;
                     w_pop      = 1'b1;
                  end
               end else if (!kes_busy_i) begin
                  w_launch    = 1'b1;
                  w_pop       = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (kes_done_i) begin
               if (w_out_free) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ld_sigma = kes_sigma_i;
      w_ld_v     = kes_v_i;
      w_ld_tag   = r_tag_fly;
      if (w_load_byp) begin
         w_ld_sigma    = '0;
         w_ld_sigma[0] = GF_ONE;
         w_ld_v        = '0;
         w_ld_tag      = w_head.tag;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tag_fly    <= '0;
         r_valid      <= 1'b0;
         r_sigma      <= '0;
         r_v          <= '0;
         r_deg        <= '0;
         r_tag        <= '0;
         r_bypass     <= 1'b0;
         r_cnt_solved <= '0;
         r_cnt_bypass <= '0;
      end else begin
         if (w_launch) begin
            r_tag_fly    <= w_head.tag;
            r_cnt_solved <= r_cnt_solved + CNTW'(1);
         end
         if (w_load_byp) r_cnt_bypass <= r_cnt_bypass + CNTW'(1);
         if (w_load) begin
            r_valid  <= 1'b1;
            r_sigma  <= w_ld_sigma;
            r_v      <= w_ld_v;
            r_deg    <= sigma_deg(w_ld_sigma);
            r_tag    <= w_ld_tag;
            r_bypass <= w_load_byp;
         end else if (m_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign s_ready_o       = !w_full;
   assign kes_start_o     = w_launch;
   assign kes_syn_valid_o = w_launch;
   assign kes_syn_o       = w_head.syn;
   assign m_valid_o       = r_valid;
   assign m_sigma_o       = r_sigma;
   assign m_v_o           = r_v;
   assign m_deg_o         = r_deg;
   assign m_tag_o         = r_tag;
   assign m_bypass_o      = r_bypass;
   assign cnt_solved_o    = r_cnt_solved;
   assign cnt_bypass_o    = r_cnt_bypass;

endmodule

// File: tb/tb_ribm_kes_scheduler.sv
// Scoreboard bench for ribm_kes_scheduler with a behavioural 2T-cycle solver model.
module tb_ribm_kes_scheduler;
   import ribm_pkg::*;

   typedef struct packed {
      sigma_vec_t      sigma;
      v_vec_t          v;
      logic [DEGW-1:0] deg;
      logic [TAGW-1:0] tag;
      logic            bypass;
   } res_t;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            s_valid_i = 1'b0;
   logic            s_ready_o;
   syn_vec_t        s_syn_i = '0;
   logic [TAGW-1:0] s_tag_i = '0;
   logic            kes_start_o, kes_syn_valid_o;
   syn_vec_t        kes_syn_o;
   logic            kes_busy_i, kes_done_i;
   sigma_vec_t      kes_sigma_i;
   v_vec_t          kes_v_i;
   logic            m_valid_o;
   logic            m_ready_i = 1'b1;
   sigma_vec_t      m_sigma_o;
   v_vec_t          m_v_o;
   logic [DEGW-1:0] m_deg_o;
   logic [TAGW-1:0] m_tag_o;
   logic            m_bypass_o;
   logic [CNTW-1:0] cnt_solved_o, cnt_bypass_o;

   ribm_kes_scheduler dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_syn_i(s_syn_i), .s_tag_i(s_tag_i),
      .kes_start_o(kes_start_o), .kes_syn_valid_o(kes_syn_valid_o), .kes_syn_o(kes_syn_o),
      .kes_busy_i(kes_busy_i), .kes_done_i(kes_done_i),
      .kes_sigma_i(kes_sigma_i), .kes_v_i(kes_v_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_sigma_o(m_sigma_o), .m_v_o(m_v_o),
      .m_deg_o(m_deg_o), .m_tag_o(m_tag_o), .m_bypass_o(m_bypass_o),
      .cnt_solved_o(cnt_solved_o), .cnt_bypass_o(cnt_bypass_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_starts = 0;
   int   last_start = -1;
   int   exp_solved = 0;
   int   exp_bypass = 0;
   logic saw_full = 1'b0;
   res_t exp_q[$];

   task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   // Solver model: sigma degree taken from s[2][3:0], all-zero sigma when s[2][4] is set.
   function automatic sigma_vec_t model_sigma(input syn_vec_t s);
      sigma_vec_t r = '0;
      for (int i = 0; i <= int'(T); i++)
         if (!s[2][4] && i <= int'(s[2][3:0])) r[i] = s[1] ^ W'(i);
      return r;
   endfunction

   function automatic v_vec_t model_v(input syn_vec_t s);
      v_vec_t r;
      for (int i = 0; i < int'(T); i++) r[i] = s[3] + W'(i);
      return r;
   endfunction

   function automatic syn_vec_t mk_syn(input int deg, input logic zs, input logic [W-1:0] seed);
      syn_vec_t s;
      for (int i = 0; i < int'(NSYN); i++) s[i] = W'($urandom);
      s[1] = 10'h200 | seed;
      s[2] = W'({zs, 4'(deg)});
      return s;
   endfunction

   always @(posedge clk_i) cyc <= cyc + 1;

   syn_vec_t   m_syn;
   int         m_cnt;
   logic       m_busy, m_done;
   sigma_vec_t m_sig;
   v_vec_t     m_vv;
   assign kes_busy_i  = m_busy;
   assign kes_done_i  = m_done;
   assign kes_sigma_i = m_sig;
   assign kes_v_i     = m_vv;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
         m_syn <= '0; m_sig <= '0; m_vv <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_sig  <= model_sigma(m_syn);
               m_vv   <= model_v(m_syn);
            end
            m_cnt <= m_cnt - 1;
         end
         if (kes_start_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 2 * int'(T) - 1;
            m_syn  <= kes_syn_o;
         end
      end
   end

   // Output monitor: scoreboard pops, stall stability and launch sanity.
   logic prev_stall = 1'b0;
   res_t held, cur, e;
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_stall = 1'b0;
      end else begin
         cur = {m_sigma_o, m_v_o, m_deg_o, m_tag_o, m_bypass_o};
         if (!s_ready_o) saw_full = 1'b1;
         if (kes_start_o) begin
            n_starts++;
            last_start = cyc;
            check_eq("start_while_busy", kes_busy_i, 1'b0);
            check_eq("syn_valid_with_start", kes_syn_valid_o, 1'b1);
         end
         if (prev_stall) check_eq("stall_stable", cur, held);
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_output", m_valid_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check_eq("out_tag", m_tag_o, e.tag);
               check_eq("out_bypass", m_bypass_o, e.bypass);
               check_eq("out_deg", m_deg_o, e.deg);
               check_eq("out_sigma", m_sigma_o, e.sigma);
               check_eq("out_v", m_v_o, e.v);
            end
         end
         prev_stall = m_valid_o && !m_ready_i;
         held = cur;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic send(input syn_vec_t s, input logic [TAGW-1:0] tag, output int a);
      res_t r;
      logic z;
      z = 1'b1;
      for (int i = 1; i < int'(NSYN); i++) if (s[i] != '0) z = 1'b0;
      if (z) begin
         r = '0;
         r.sigma[0] = 10'd1;
         r.bypass = 1'b1;
      end else begin
         r.sigma  = model_sigma(s);
         r.v      = model_v(s);
         r.deg    = s[2][4] ? '0 : DEGW'(s[2][3:0]);
         r.bypass = 1'b0;
      end
      r.tag = tag;
      s_valid_i = 1'b1; s_syn_i = s; s_tag_i = tag;
      a = -1;
      for (int k = 0; k < 200 && a < 0; k++) begin
         if (s_ready_o) begin
            a = cyc;
            exp_q.push_back(r);
            if (z) exp_bypass++; else exp_solved++;
         end
         step();
      end
      s_valid_i = 1'b0;
      if (a < 0) check_eq("send_timeout", s_ready_o, 1'b1);
   endtask

   task automatic wait_valid(output int c);
      c = -1;
      for (int k = 0; k < 200 && c < 0; k++) begin
         if (m_valid_o) c = cyc;
         else step();
      end
      if (c < 0) check_eq("valid_timeout", m_valid_o, 1'b1);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || m_valid_o) && k < 600) begin
         step();
         k++;
      end
      check_eq({tag, "_drained"}, exp_q.size(), 0);
      check_eq({tag, "_cnt_solved"}, cnt_solved_o, CNTW'(exp_solved));
      check_eq({tag, "_cnt_bypass"}, cnt_bypass_o, CNTW'(exp_bypass));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int a, c, base;
      syn_vec_t s;

      repeat (3) step();
      rst_ni = 1'b1;
      step();
      check_eq("rst_m_valid", m_valid_o, 1'b0);
      check_eq("rst_m_tag", m_tag_o, 0);
      check_eq("rst_cnt_solved", cnt_solved_o, 0);
      check_eq("rst_cnt_bypass", cnt_bypass_o, 0);
      check_eq("rst_s_ready", s_ready_o, 1'b1);
      check_eq("rst_kes_start", kes_start_o, 1'b0);

      // Zero syndrome (s[0] ignored) takes the bypass path.
      base = n_starts;
      s = '0; s[0] = 10'd5;
      send(s, 8'h11, a);
      wait_valid(c);
      check_eq("bypass_latency", c - a, 2);
      drain("bypass");
      check_eq("bypass_no_start", n_starts - base, 0);

      // Single solved codeword with degree 4.
      send(mk_syn(4, 1'b0, 10'h3), 8'h22, a);
      wait_valid(c);
      check_eq("start_latency", last_start - a, 1);
      check_eq("solve_latency", c - a, 24);
      drain("solve");

      // Back-to-back: nonzero (deg T), zero, nonzero with only s[2T] set.
      saw_full = 1'b0;
      send(mk_syn(int'(T), 1'b0, 10'h7), 8'h01, a);
      s = '0;
      send(s, 8'h02, a);
      s = '0; s[2*T] = 10'd1;
      send(s, 8'h03, a);
      drain("b2b");
      check_eq("b2b_saw_full", saw_full, 1'b1);

      // Stalled output: second solve finishes into HOLD, third must not launch.
      base = n_starts;
      m_ready_i = 1'b0;
      send(mk_syn(2, 1'b0, 10'h11), 8'h40, a);
      send(mk_syn(7, 1'b0, 10'h22), 8'h41, a);
      send(mk_syn(3, 1'b1, 10'h33), 8'h42, a);
      wait_valid(c);
      repeat (40) step();
      check_eq("hold_starts", n_starts - base, 2);
      check_eq("hold_tag", m_tag_o, 8'h40);
      check_eq("hold_valid", m_valid_o, 1'b1);
      m_ready_i = 1'b1;
      drain("hold");
      check_eq("hold_starts_after", n_starts - base, 3);

      // Reset while the solver is running.
      send(mk_syn(5, 1'b0, 10'h44), 8'h55, a);
      repeat (6) step();
      rst_ni = 1'b0;
      #1;
      check_eq("midrst_m_valid", m_valid_o, 1'b0);
      check_eq("midrst_kes_start", kes_start_o, 1'b0);
      check_eq("midrst_syn_valid", kes_syn_valid_o, 1'b0);
      check_eq("midrst_cnt_solved", cnt_solved_o, 0);
      check_eq("midrst_cnt_bypass", cnt_bypass_o, 0);
      check_eq("midrst_m_sigma", m_sigma_o, 0);
      exp_q.delete();
      exp_solved = 0;
      exp_bypass = 0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();
      check_eq("postrst_s_ready", s_ready_o, 1'b1);
      send(mk_syn(5, 1'b0, 10'h55), 8'h56, a);
      wait_valid(c);
      check_eq("postrst_latency", c - a, 24);
      drain("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
